// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the Otter instruction fetch stage.
// State encodings, the default reset PC and small PC helpers live here.
package otter_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    typedef enum logic [1:0] {
        FETCH_ST_FETCH = 2'd0,
        FETCH_ST_HOLD  = 2'd1,
        FETCH_ST_FLUSH = 2'd2,
        FETCH_ST_FAULT = 2'd3
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    // 32-bit modulo increment: 32'hFFFF_FFFC wraps to 0.
    function automatic logic [31:0] next_pc(input logic [31:0] addr);
        return addr + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/otter_fetch.sv
// Otter instruction fetch: single-outstanding word reads from instruction memory,
// one registered instruction slot toward decode, and a redirect port that flushes.
module otter_fetch
    import otter_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic         o_imem_req,
    output logic [31:0]  o_imem_addr,
    input  logic         i_imem_ack,
    input  logic [31:0]  i_imem_rdata,
    output logic         o_instrn_valid,
    input  logic         i_ready,
    output logic [31:0]  o_instrn,
    output logic [31:0]  o_pc,
    input  logic         i_redirect,
    input  logic [31:0]  i_redirect_pc,
    output logic         o_fault,
    output fetch_state_e o_state
);

    // Handshakes:
    //   imem:   o_imem_req/o_imem_addr hold steady until i_imem_ack; a request is never withdrawn.
    //   decode: an instruction transfers on o_instrn_valid & i_ready; the slot is stable otherwise.

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  req_addr;
    logic         flush_to_fault;

    logic         hold_take;
    logic         mem_ack;
    logic         target_bad;
    logic [31:0]  req_next;

    assign hold_take   = (state == FETCH_ST_HOLD) && i_ready && !i_redirect;
    assign o_imem_req  = !i_rst && ((state == FETCH_ST_FETCH) ||
                                    (state == FETCH_ST_FLUSH) || hold_take);
    assign o_imem_addr = req_addr;
    assign mem_ack     = o_imem_req && i_imem_ack;
    assign target_bad  = is_misaligned(i_redirect_pc);
    assign req_next    = next_pc(req_addr);
    assign o_state     = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= FETCH_ST_FETCH;
            pc             <= RESET_PC;
            req_addr       <= RESET_PC;
            flush_to_fault <= 1'b0;
            o_instrn_valid <= 1'b0;
            o_instrn       <= 32'd0;
            o_pc           <= RESET_PC;
            o_fault        <= 1'b0;
        end else begin
            case (state)
                FETCH_ST_FETCH: begin
                    if (i_redirect) begin
                        o_instrn_valid <= 1'b0;
                        pc             <= i_redirect_pc;
                        if (mem_ack) begin
                            // Returned word belongs to the old path; drop it.
                            req_addr <= i_redirect_pc;
                            state    <= target_bad ? FETCH_ST_FAULT : FETCH_ST_FETCH;
                            o_fault  <= target_bad;
                        end else begin
                            flush_to_fault <= target_bad;
                            state          <= FETCH_ST_FLUSH;
                        end
                    end else if (mem_ack) begin
                        o_instrn       <= i_imem_rdata;
                        o_pc           <= req_addr;
                        o_instrn_valid <= 1'b1;
                        req_addr       <= req_next;
                        pc             <= req_next;
                        state          <= FETCH_ST_HOLD;
                    end
                end

                FETCH_ST_HOLD: begin
                    if (i_redirect) begin
                        o_instrn_valid <= 1'b0;
                        pc             <= i_redirect_pc;
                        req_addr       <= i_redirect_pc;
                        state          <= target_bad ? FETCH_ST_FAULT : FETCH_ST_FETCH;
                        o_fault        <= target_bad;
                    end else if (i_ready) begin
                        // Slot consumed; the request at pc went out this same cycle.
                        if (mem_ack) begin
                            o_instrn       <= i_imem_rdata;
                            o_pc           <= req_addr;
                            o_instrn_valid <= 1'b1;
                            req_addr       <= req_next;
                            pc             <= req_next;
                        end else begin
                            o_instrn_valid <= 1'b0;
                            state          <= FETCH_ST_FETCH;
                        end
                    end
                end

                FETCH_ST_FLUSH: begin
                    if (i_redirect) begin
                        pc <= i_redirect_pc;
                        if (mem_ack) begin
                            req_addr <= i_redirect_pc;
                            state    <= target_bad ? FETCH_ST_FAULT : FETCH_ST_FETCH;
                            o_fault  <= target_bad;
                        end else begin
                            flush_to_fault <= target_bad;
                        end
                    end else if (mem_ack) begin
                        req_addr <= pc;
                        state    <= flush_to_fault ? FETCH_ST_FAULT : FETCH_ST_FETCH;
                        o_fault  <= flush_to_fault;
                    end
                end

                FETCH_ST_FAULT: begin
                    if (i_redirect) begin
                        pc <= i_redirect_pc;
                        if (!target_bad) begin
                            req_addr <= i_redirect_pc;
                            state    <= FETCH_ST_FETCH;
                            o_fault  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= FETCH_ST_FETCH;
                end
            endcase
        end
    end

endmodule
